// File: rtl/enemy_flyer_draw_ctrl.sv
// enemy_flyer_draw_ctrl: shares the enemy-flyer sprite ROM among N_ENEMY requesters
// and pipelines the returned color index to the palette, with per-enemy hit-flash.
module enemy_flyer_draw_ctrl #(
    parameter int         N_ENEMY      = 4,
    parameter int         ADDR_W       = 10,
    parameter int         FLASH_FRAMES = 8,
    parameter logic [3:0] FLASH_INDEX  = 4'h3
) (
    input  logic                        Clk,
    input  logic                        Reset,
    input  logic                        frame_start,
    input  logic [N_ENEMY-1:0]          req,
    input  logic [N_ENEMY*ADDR_W-1:0]   req_addr,
    input  logic [N_ENEMY-1:0]          flash_trig,
    output logic [ADDR_W-1:0]           rom_addr,
    input  logic [3:0]                  rom_data,
    output logic [3:0]                  pal_index,
    output logic                        pix_valid,
    output logic [2:0]                  grant_id,
    output logic [N_ENEMY-1:0]          flashing
);
    logic [2:0]        win;
    logic [ADDR_W-1:0] win_addr;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
    logic [2:0]        s1_id_q, s1_id_d, s2_id_q, s2_id_d;
    logic [3:0]        pal_index_q, pal_index_d;
    logic              pix_valid_q, pix_valid_d;
    logic [2:0]        grant_id_q, grant_id_d;
    logic [7:0]        cnt_q [N_ENEMY];
    logic [7:0]        cnt_d [N_ENEMY];
    logic [7:0]        flash_on;
    logic              opaque;

    always_comb begin
        win      = '0;
        win_addr = req_addr[ADDR_W-1:0];
        // Descending scan so the lowest set request bit is the last to win.
        for (int i = N_ENEMY - 1; i >= 0; i--) begin
            if (req[i]) begin
                win      = 3'(i);
                win_addr = req_addr[i*ADDR_W +: ADDR_W];
            end
        end
        flashing = '0;
        flash_on = '0;
        for (int i = 0; i < N_ENEMY; i++) begin
            flashing[i] = cnt_q[i] != 8'd0;
            flash_on[i] = flashing[i] && cnt_q[i][0];
            cnt_d[i]    = flash_trig[i] ? 8'(FLASH_FRAMES)
                        : (frame_start && flashing[i]) ? cnt_q[i] - 8'd1 : cnt_q[i];
        end
        rom_addr_d  = |req ? win_addr : rom_addr_q;
        s1_valid_d  = |req;
        s1_id_d     = win;
        s2_valid_d  = s1_valid_q;
        s2_id_d     = s1_id_q;
        opaque      = s2_valid_q && rom_data != 4'h0;
        pix_valid_d = opaque;
        grant_id_d  = s2_id_q;
        pal_index_d = !opaque ? 4'h0 : flash_on[s2_id_q] ? FLASH_INDEX : rom_data;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            rom_addr_q  <= '0;
            s1_valid_q  <= 1'b0;
            s1_id_q     <= '0;
            s2_valid_q  <= 1'b0;
            s2_id_q     <= '0;
            pal_index_q <= '0;
            pix_valid_q <= 1'b0;
            grant_id_q  <= '0;
            cnt_q       <= '{default: '0};
        end else begin
            rom_addr_q  <= rom_addr_d;
            s1_valid_q  <= s1_valid_d;
            s1_id_q     <= s1_id_d;
            s2_valid_q  <= s2_valid_d;
            s2_id_q     <= s2_id_d;
            pal_index_q <= pal_index_d;
            pix_valid_q <= pix_valid_d;
            grant_id_q  <= grant_id_d;
            cnt_q       <= cnt_d;
        end
    end

    assign rom_addr  = rom_addr_q;
    assign pal_index = pal_index_q;
    assign pix_valid = pix_valid_q;
    assign grant_id  = grant_id_q;
endmodule

// File: tb/tb_enemy_flyer_draw_ctrl.sv
// tb_enemy_flyer_draw_ctrl: directed vectors against enemy_flyer_draw_ctrl with a
// synchronous sprite ROM model.
module tb_enemy_flyer_draw_ctrl;
    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        frame_start = 1'b0;
    logic [3:0]  req = '0;
    logic [39:0] req_addr = '0;
    logic [3:0]  flash_trig = '0;
    logic [9:0]  rom_addr;
    logic [3:0]  rom_data = '0;
    logic [3:0]  pal_index;
    logic        pix_valid;
    logic [2:0]  grant_id;
    logic [3:0]  flashing;
    logic [3:0]  rom [0:1023];
    int          checks = 0;
    int          errors = 0;

    enemy_flyer_draw_ctrl dut (
        .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .req(req),
        .req_addr(req_addr), .flash_trig(flash_trig), .rom_addr(rom_addr),
        .rom_data(rom_data), .pal_index(pal_index), .pix_valid(pix_valid),
        .grant_id(grant_id), .flashing(flashing)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) rom_data <= rom[rom_addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] r, input logic [9:0] a0, input logic [9:0] a1,
                         input logic [9:0] a2, input logic [9:0] a3);
        req      = r;
        req_addr = {a3, a2, a1, a0};
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            frame_start = 1'b1;
            tick();
            frame_start = 1'b0;
            tick();
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = 4'h1;
        rom[10'h055] = 4'h5;
        rom[10'h010] = 4'hA;
        rom[10'h020] = 4'hE;
        rom[10'h021] = 4'h2;
        rom[10'h022] = 4'hC;
        rom[10'h023] = 4'h9;
        rom[10'h030] = 4'h0;
        rom[10'h040] = 4'h7;
        repeat (3) tick();
        chk("rst_rom_addr", 32'(rom_addr), 0);
        chk("rst_pal", 32'(pal_index), 0);
        chk("rst_pix", 32'(pix_valid), 0);
        chk("rst_flashing", 32'(flashing), 0);
        Reset = 1'b0;
        // single requester
        drive(4'b0100, 0, 0, 10'h055, 0);
        tick();
        chk("single_rom_addr", 32'(rom_addr), 32'h55);
        drive(0, 0, 0, 0, 0);
        tick();
        tick();
        chk("single_pal", 32'(pal_index), 5);
        chk("single_pix", 32'(pix_valid), 1);
        chk("single_gid", 32'(grant_id), 2);
        // priority then streaming
        drive(4'b1010, 0, 10'h010, 0, 10'h020);
        tick();
        chk("prio_rom_addr", 32'(rom_addr), 32'h10);
        drive(4'b0001, 10'h021, 0, 0, 0);
        tick();
        chk("stream_rom_addr", 32'(rom_addr), 32'h21);
        drive(4'b0001, 10'h022, 0, 0, 0);
        tick();
        chk("prio_pal", 32'(pal_index), 32'hA);
        chk("prio_gid", 32'(grant_id), 1);
        drive(4'b0001, 10'h023, 0, 0, 0);
        tick();
        chk("stream_pal0", 32'(pal_index), 2);
        chk("stream_gid0", 32'(grant_id), 0);
        drive(0, 0, 0, 0, 0);
        tick();
        chk("stream_pal1", 32'(pal_index), 32'hC);
        chk("idle_rom_addr_hold", 32'(rom_addr), 32'h23);
        tick();
        chk("stream_pal2", 32'(pal_index), 9);
        chk("stream_pix2", 32'(pix_valid), 1);
        // transparent winner does not fall through to enemy 1
        drive(4'b0011, 10'h030, 10'h055, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        tick();
        tick();
        chk("transp_pix", 32'(pix_valid), 0);
        chk("transp_pal", 32'(pal_index), 0);
        tick();
        chk("noreq_pix", 32'(pix_valid), 0);
        // flash blink on enemy 0
        drive(4'b0001, 10'h040, 0, 0, 0);
        flash_trig = 4'b0001;
        tick();
        flash_trig = 4'b0000;
        for (int f = 0; f <= 8; f++) begin
            repeat (3) tick();
            chk("flash_pal", 32'(pal_index), ((8 - f) % 2 == 1) ? 3 : 7);
            chk("flash_active", 32'(flashing[0]), (f < 8) ? 1 : 0);
            if (f < 8) begin
                frame_start = 1'b1;
                tick();
                frame_start = 1'b0;
            end
        end
        drive(0, 0, 0, 0, 0);
        // trigger and frame_start collide: load wins
        flash_trig  = 4'b0010;
        frame_start = 1'b1;
        tick();
        flash_trig  = 4'b0000;
        frame_start = 1'b0;
        chk("collide_flashing", 32'(flashing), 32'b0010);
        frames(7);
        chk("collide_after7", 32'(flashing[1]), 1);
        frames(1);
        chk("collide_after8", 32'(flashing[1]), 0);
        // retrigger at cnt = 2 reloads to 8
        flash_trig = 4'b0010;
        tick();
        flash_trig = 4'b0000;
        frames(6);
        chk("retrig_cnt2", 32'(flashing[1]), 1);
        flash_trig = 4'b0010;
        tick();
        flash_trig = 4'b0000;
        frames(7);
        chk("retrig_after7", 32'(flashing[1]), 1);
        frames(1);
        chk("retrig_after8", 32'(flashing[1]), 0);
        // reset mid-flash with a full pipeline, cnt[2] = 5
        flash_trig = 4'b0100;
        tick();
        flash_trig = 4'b0000;
        frames(3);
        drive(4'b0100, 0, 0, 10'h055, 0);
        repeat (3) tick();
        chk("full_pix", 32'(pix_valid), 1);
        chk("full_pal_flash", 32'(pal_index), 3);
        Reset = 1'b1;
        tick();
        chk("midrst_pal", 32'(pal_index), 0);
        chk("midrst_pix", 32'(pix_valid), 0);
        chk("midrst_gid", 32'(grant_id), 0);
        chk("midrst_rom_addr", 32'(rom_addr), 0);
        chk("midrst_flashing", 32'(flashing), 0);
        Reset = 1'b0;
        drive(0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("post_rst_pix", 32'(pix_valid), 0);
        end
        drive(4'b0100, 0, 0, 10'h055, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        tick();
        chk("post_rst_early", 32'(pix_valid), 0);
        tick();
        chk("post_rst_pal", 32'(pal_index), 5);
        chk("post_rst_pix1", 32'(pix_valid), 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/enemy_flyer_draw_ctrl.md
# enemy_flyer_draw_ctrl

Per-pixel draw controller that shares one synchronous enemy-flyer sprite ROM and the enemy-flyer color palette among up to N_ENEMY enemy instances. Each cycle it grants the highest-priority requesting enemy and drives the granted address into the ROM. It pipelines the returned 4-bit color index to the palette input, flags transparency, and applies a per-enemy hit-flash override sequenced by frame count. It sits between the enemy position/hit-test logic and the palette-to-VGA color mux.

## Interface
Parameters:
- N_ENEMY, 4: number of requesters; 1..8.
- ADDR_W, 10: sprite ROM address width.
- FLASH_FRAMES, 8: frames a hit-flash lasts; 1..255.
- FLASH_INDEX, 4'h3: palette index substituted while flashing (yellow entry).

Ports:
- Clk  in  1  system clock; single clock domain.
- Reset  in  1  synchronous, active-high.
- frame_start  in  1  one-cycle pulse at start of each frame (vsync edge).
- req  in  N_ENEMY  bit i high: enemy i covers the current pixel.
- req_addr  in  N_ENEMY*ADDR_W  enemy i ROM address in bits [i*ADDR_W +: ADDR_W].
- flash_trig  in  N_ENEMY  one-cycle pulse per enemy: start/restart hit-flash.
- rom_addr  out  ADDR_W  registered address to sprite ROM.
- rom_data  in  4  ROM color index, valid one cycle after rom_addr.
- pal_index  out  4  registered index to palette data_in.
- pix_valid  out  1  palette output is an opaque enemy pixel this cycle.
- grant_id  out  3  enemy index that produced pal_index.
- flashing  out  N_ENEMY  per-enemy flash-active status.

## Operation
- Arbitration (stage 0): fixed priority, lowest set bit of req wins. If req == 0, there is no grant.
  - Registers rom_addr = req_addr slice of the winner.
  - Registers s1_valid = |req and s1_id = winner.
  - With no grant, rom_addr holds its previous value and s1_valid = 0.
- Stage 1: ROM returns rom_data.
  - s2_valid <= s1_valid and s2_id <= s1_id.
  - Both are aligned with rom_data.
- Stage 2 (output register):
  - opaque = s2_valid && rom_data != 4'h0. Index 0 is the transparent key (pink).
  - pix_valid <= opaque.
  - grant_id <= s2_id.
  - pal_index <= FLASH_INDEX if opaque and flash_on[s2_id]; else rom_data if opaque; else 4'h0.
- Flash sequencer, one 8-bit down-counter cnt[i] per enemy, states IDLE (cnt == 0) and FLASH (cnt != 0):
  - A flash_trig[i] pulse loads cnt[i] = FLASH_FRAMES in any state. Retrigger restarts the flash.
  - frame_start with cnt[i] != 0 decrements cnt[i].
  - flash_trig[i] and frame_start in the same cycle: load wins, no decrement.
  - flashing[i] = (cnt[i] != 0).
  - flash_on[i] = flashing[i] && cnt[i][0]. The enemy blinks on alternate frames.
- Transparent pixels of the winning enemy are not resolved to a lower-priority enemy. Background shows through.
- The arithmetic saturates at 0. The counter never wraps below 0.

## Timing
- Latency: req/req_addr sampled at edge t, rom_addr valid after t, rom_data valid after t+1, and pal_index/pix_valid/grant_id valid after t+2. Total is 3 cycles.
- Throughput is one pixel per clock, with no stalls and no backpressure.
- flash_trig takes effect in the flashing output 1 cycle after the pulse edge. It affects any pixel whose stage-2 capture occurs after the load.
- Reset (synchronous, any cycle, including mid-pipeline or mid-flash):
  - rom_addr = 0, pal_index = 0, pix_valid = 0, grant_id = 0, flashing = 0.
  - All cnt = 0 and all pipeline valids = 0.
  - The first valid output after reset release appears 3 cycles after the first req.
- frame_start affects only the counters. The pixel pipeline is not flushed.

## Test plan
- Single requester: req = 4'b0100, addr 10'h055, ROM[0x55] = 4'h5. Required response 3 cycles later: pal_index = 5, pix_valid = 1, grant_id = 2.
- Priority: req = 4'b1010 with addrs 0x10 (enemy 1) and 0x20 (enemy 3). Required: rom_addr = 0x10, grant_id = 1. A continuous stream of changing addresses yields one output per clock, in order.
- Transparency: the granted ROM entry = 4'h0. Required: pix_valid = 0 and pal_index = 0. With req = 0, pix_valid = 0 three cycles later.
- Flash: FLASH_FRAMES = 8, pulse flash_trig[0], then issue 8 frame_starts with enemy 0 opaque index 4'h7.
  - pal_index alternates 3 (cnt odd) and 7 (cnt even).
  - flashing[0] drops after the 8th frame_start, after which index 7 persists.
- Collision and retrigger: flash_trig[1] and frame_start in the same cycle leaves cnt = FLASH_FRAMES. A retrigger at cnt = 2 reloads to 8.
- Reset mid-operation: assert Reset while the pipeline is full and cnt[2] = 5. The next cycle shows all outputs 0 and flashing = 0, with no stale pix_valid after release.
